// File: rtl/jtdsp16_prog_loader.sv
// Packs a download byte stream into 16-bit program words for the jtdsp16 core and keeps the core in reset during the load.
// Define JTDSP16_LOADER_CHKSUM_EN to add a 16-bit running sum of the written words on the chksum port.
module jtdsp16_prog_loader #(
  parameter int AW         = 12,
  parameter int PROG_WORDS = 4096,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int RST_HOLD   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dl_start,
  input  logic [7:0]    dl_data,
  input  logic          dl_we,
  input  logic          dl_done,
  output logic          dl_ready,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic          prog_we,
  output logic          dsp_rst,
  output logic          busy,
  output logic [AW:0]   words,
  output logic          err
`ifdef JTDSP16_LOADER_CHKSUM_EN
  ,
  output logic [15:0]   chksum
`endif
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, RELEASE, RUN} state_t;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [AW+1:0] PW_L     = (AW+2)'(PROG_WORDS);
  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_t          state, state_nx;
  logic            wr_pend;
  logic [7:0]      first_byte;
  logic [HW-1:0]   hold_cnt;
  logic [AW+1:0]   pend_cnt;
  logic            start, acc, done, full, hold_last;

  function automatic logic [15:0] pack(input logic [7:0] a, input logic [7:0] b);
    return BIG_ENDIAN ? {a, b} : {b, a};
  endfunction

  assign start     = dl_start & cen;
  assign acc       = dl_we & dl_ready;
  assign done      = dl_done & cen;
  // A word still waiting for its write slot already counts against capacity.
  assign pend_cnt  = {1'b0, words} + {{(AW+1){1'b0}}, wr_pend};
  assign full      = pend_cnt >= PW_L;
  assign hold_last = hold_cnt == HW'(RST_HOLD - 1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred on untaken paths.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = LOAD_A;
    end else if (cen) begin
      case (state)
        LOAD_A:  if (done) state_nx = RELEASE;
                 else if (acc && !full) state_nx = LOAD_B;
        LOAD_B:  if (done) state_nx = RELEASE;
                 else if (acc) state_nx = LOAD_A;
        RELEASE: if (!wr_pend && hold_last) state_nx = RUN;
        default: ;
      endcase
    end
  end

  always_comb begin
    dl_ready = 1'b0;
    dsp_rst  = 1'b1;
    busy     = 1'b0;
    case (state)
      LOAD_A, LOAD_B: begin
        dl_ready = cen;
        busy     = 1'b1;
      end
      RELEASE: busy    = 1'b1;
      RUN:     dsp_rst = 1'b0;
      default: ;
    endcase
    prog_we = wr_pend & cen;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend    <= 1'b0;
      prog_data  <= '0;
      first_byte <= '0;
      prog_addr  <= '0;
      words      <= '0;
      err        <= 1'b0;
      hold_cnt   <= '0;
    end else if (cen) begin
      if (start) begin
        wr_pend    <= 1'b0;
        first_byte <= '0;
        prog_addr  <= '0;
        words      <= '0;
        err        <= 1'b0;
        hold_cnt   <= '0;
      end else begin
        if (prog_we) begin
          wr_pend <= 1'b0;
          words   <= words + (AW+1)'(1);
          if (prog_addr != ADDR_MAX) prog_addr <= prog_addr + AW'(1);
        end
        if (state == RELEASE && !wr_pend) hold_cnt <= hold_cnt + HW'(1);
        case (state)
          LOAD_A: if (acc) begin
            if (full) begin
              err <= 1'b1;
            end else if (done) begin
              prog_data <= pack(dl_data, 8'h00);
              wr_pend   <= 1'b1;
            end else begin
              first_byte <= dl_data;
            end
          end
          LOAD_B: if (acc) begin
            prog_data <= pack(first_byte, dl_data);
            wr_pend   <= 1'b1;
          end else if (done) begin
            prog_data <= pack(first_byte, 8'h00);
            wr_pend   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef JTDSP16_LOADER_CHKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          chksum <= '0;
    else if (start)   chksum <= '0;
    else if (prog_we) chksum <= chksum + prog_data;
  end
`endif

endmodule

// File: tb/tb_jtdsp16_prog_loader.sv
// Scoreboard bench for jtdsp16_prog_loader: a big-endian instance with PROG_WORDS=4 and a little-endian default instance.
module tb_jtdsp16_prog_loader;

  localparam int AW = 12;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  logic clk = 1'b0, rst = 1'b1, cen = 1'b1;
  logic d_start = 1'b0, d_we = 1'b0, d_done = 1'b0;
  logic [7:0] d_data = 8'h00;
  bit sel = 1'b0, tog = 1'b0;

  logic          be_ready, be_we, be_dsp, be_busy, be_err;
  logic [AW-1:0] be_addr;
  logic [15:0]   be_data, be_chk;
  logic [AW:0]   be_words;
  logic          le_ready, le_we, le_dsp, le_busy, le_err;
  logic [AW-1:0] le_addr;
  logic [15:0]   le_data, le_chk;
  logic [AW:0]   le_words;

  wr_t q_be[$], q_le[$];
  wr_t e_be, e_le;
  int n_chk = 0, n_fail = 0, since = 0;

  wire m_ready = sel ? le_ready : be_ready;
  wire m_we    = sel ? le_we    : be_we;
  wire m_dsp   = sel ? le_dsp   : be_dsp;
  wire m_busy  = sel ? le_busy  : be_busy;

  always #5 clk = ~clk;

  jtdsp16_prog_loader #(.AW(AW), .PROG_WORDS(4), .BIG_ENDIAN(1'b1), .RST_HOLD(4)) dut_be (
    .clk(clk), .rst(rst), .cen(cen),
    .dl_start(sel ? 1'b0 : d_start), .dl_data(d_data),
    .dl_we(sel ? 1'b0 : d_we), .dl_done(sel ? 1'b0 : d_done),
    .dl_ready(be_ready), .prog_addr(be_addr), .prog_data(be_data), .prog_we(be_we),
    .dsp_rst(be_dsp), .busy(be_busy), .words(be_words), .err(be_err)
`ifdef JTDSP16_LOADER_CHKSUM_EN
    , .chksum(be_chk)
`endif
  );

  jtdsp16_prog_loader #(.AW(AW), .PROG_WORDS(4096), .BIG_ENDIAN(1'b0), .RST_HOLD(4)) dut_le (
    .clk(clk), .rst(rst), .cen(cen),
    .dl_start(sel ? d_start : 1'b0), .dl_data(d_data),
    .dl_we(sel ? d_we : 1'b0), .dl_done(sel ? d_done : 1'b0),
    .dl_ready(le_ready), .prog_addr(le_addr), .prog_data(le_data), .prog_we(le_we),
    .dsp_rst(le_dsp), .busy(le_busy), .words(le_words), .err(le_err)
`ifdef JTDSP16_LOADER_CHKSUM_EN
    , .chksum(le_chk)
`endif
  );

`ifndef JTDSP16_LOADER_CHKSUM_EN
  assign be_chk = 16'h0;
  assign le_chk = 16'h0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every write strobe is matched against the head of its scoreboard queue.
  always @(negedge clk) begin
    if (be_we) begin
      check("be_we_cen", {31'b0, cen}, 32'd1);
      if (q_be.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL be_unexpected_we: got addr %h data %h expected no write", be_addr, be_data);
      end else begin
        e_be = q_be.pop_front();
        check("be_addr", {20'b0, be_addr}, {20'b0, e_be.addr});
        check("be_data", {16'b0, be_data}, {16'b0, e_be.data});
      end
    end
    if (le_we) begin
      check("le_we_cen", {31'b0, cen}, 32'd1);
      if (q_le.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL le_unexpected_we: got addr %h data %h expected no write", le_addr, le_data);
      end else begin
        e_le = q_le.pop_front();
        check("le_addr", {20'b0, le_addr}, {20'b0, e_le.addr});
        check("le_data", {16'b0, le_data}, {16'b0, e_le.data});
      end
    end
    if (m_we) since = 0;
    else if (cen && m_dsp && m_busy) since++;
  end

  always @(posedge clk) if (tog) begin #1; cen = ~cen; end

  task automatic expect_wr(input logic [AW-1:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    if (sel) q_le.push_back(w);
    else     q_be.push_back(w);
  endtask

  // Holds the current inputs until an edge where they are taken (cen=1, plus dl_ready if asked).
  task automatic wait_edge(input bit need_ready, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = need_ready ? m_ready : cen;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s_timeout: got no accepting edge expected one within 50 cycles", name);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit done);
    d_data = b; d_we = 1'b1; d_done = done;
    wait_edge(1'b1, "send");
    d_we = 1'b0; d_done = 1'b0;
  endtask

  task automatic pulse_start();
    d_start = 1'b1;
    wait_edge(1'b0, "start");
    d_start = 1'b0;
  endtask

  task automatic pulse_done();
    d_done = 1'b1;
    wait_edge(1'b0, "done");
    d_done = 1'b0;
  endtask

  task automatic wait_run(input string name);
    for (int i = 0; i < 300 && m_busy; i++) @(negedge clk);
    check({name, "_busy"}, {31'b0, m_busy}, 32'd0);
    check({name, "_dsp_rst"}, {31'b0, m_dsp}, 32'd0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_addr",  {20'b0, be_addr}, 32'd0);
    check("rst_data",  {16'b0, be_data}, 32'd0);
    check("rst_we",    {31'b0, be_we}, 32'd0);
    check("rst_dsp",   {31'b0, be_dsp}, 32'd1);
    check("rst_ready", {31'b0, be_ready}, 32'd0);
    check("rst_busy",  {31'b0, be_busy}, 32'd0);
    check("rst_words", {19'b0, be_words}, 32'd0);
    check("rst_err",   {31'b0, be_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Big-endian even stream.
    sel = 1'b0;
    pulse_start();
    check("t1_busy", {31'b0, be_busy}, 32'd1);
    expect_wr(0, 16'h1234); expect_wr(1, 16'hABCD);
    send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
    pulse_done();
    wait_run("t1");
    check("t1_words", {19'b0, be_words}, 32'd2);
    check("t1_addr",  {20'b0, be_addr}, 32'd2);
    check("t1_hold",  since, 32'd4);
    check("t1_err",   {31'b0, be_err}, 32'd0);
`ifdef JTDSP16_LOADER_CHKSUM_EN
    check("t1_chksum", {16'b0, be_chk}, 32'h0000BE01);
`endif

    // Little-endian instance, same stream.
    sel = 1'b1;
    pulse_start();
    expect_wr(0, 16'h3412); expect_wr(1, 16'hCDAB);
    send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
    pulse_done();
    wait_run("t2");
    check("t2_words", {19'b0, le_words}, 32'd2);
    check("t2_hold",  since, 32'd4);
    sel = 1'b0;
    @(posedge clk); #1;

    // Odd stream, done together with the last byte.
    pulse_start();
    expect_wr(0, 16'h1122); expect_wr(1, 16'h3300);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
    wait_run("t3");
    check("t3_words", {19'b0, be_words}, 32'd2);
    check("t3_hold",  since, 32'd4);

    // Overflow past PROG_WORDS=4.
    pulse_start();
    expect_wr(0, 16'h0001); expect_wr(1, 16'h0203);
    expect_wr(2, 16'h0405); expect_wr(3, 16'h0607);
    for (int i = 0; i < 10; i++) send(8'(i), 0);
    pulse_done();
    wait_run("t4");
    check("t4_err",   {31'b0, be_err}, 32'd1);
    check("t4_words", {19'b0, be_words}, 32'd4);
    check("t4_addr",  {20'b0, be_addr}, 32'd4);

    // Restart in the middle of a load.
    pulse_start();
    check("t5_err_clr", {31'b0, be_err}, 32'd0);
    expect_wr(0, 16'hA1A2); expect_wr(1, 16'hA3A4); expect_wr(2, 16'hA5A6);
    for (int i = 0; i < 6; i++) send(8'hA1 + 8'(i), 0);
    repeat (3) @(posedge clk); #1;
    check("t5_words_pre", {19'b0, be_words}, 32'd3);
    pulse_start();
    check("t5_words", {19'b0, be_words}, 32'd0);
    check("t5_addr",  {20'b0, be_addr}, 32'd0);
    check("t5_dsp",   {31'b0, be_dsp}, 32'd1);
    expect_wr(0, 16'h5AA5);
    send(8'h5A, 0); send(8'hA5, 0);
    pulse_done();
    wait_run("t5");
    check("t5_words_end", {19'b0, be_words}, 32'd1);

    // Clock enable toggling every cycle.
    tog = 1'b1;
    pulse_start();
    expect_wr(0, 16'h1234); expect_wr(1, 16'hABCD);
    send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
    pulse_done();
    wait_run("t6");
    check("t6_words", {19'b0, be_words}, 32'd2);
    check("t6_hold",  since, 32'd4);
`ifdef JTDSP16_LOADER_CHKSUM_EN
    check("t6_chksum", {16'b0, be_chk}, 32'h0000BE01);
`endif

    // Asynchronous reset while a word is half assembled.
    pulse_start();
    send(8'h77, 0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("t7_we",    {31'b0, be_we}, 32'd0);
    check("t7_dsp",   {31'b0, be_dsp}, 32'd1);
    check("t7_busy",  {31'b0, be_busy}, 32'd0);
    check("t7_ready", {31'b0, be_ready}, 32'd0);
    check("t7_data",  {16'b0, be_data}, 32'd0);
    check("t7_words", {19'b0, be_words}, 32'd0);
    repeat (5) @(posedge clk); #1;
    tog = 1'b0; cen = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t7_idle_busy", {31'b0, be_busy}, 32'd0);
    check("q_be_empty", q_be.size(), 32'd0);
    check("q_le_empty", q_le.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
